// File: rtl/mem_capture.sv
// mem_capture: receive side of the rank strobe/data link.
// The strobe is generated from clk, so it is sampled directly without
// synchronizers. A dq byte is captured on every strobe level change, and the
// bytes come out as a valid-qualified stream with done/err burst status.
module mem_capture #(
   parameter int DW        = 8,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          dqs_p,
   input  logic          dqs_n,
   input  logic [DW-1:0] dq,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code
);

   localparam int TW = $clog2(TIMEOUT + 1);

   // Strobe levels as {p,n}
   localparam logic [1:0] STB_IDLE = 2'b00;
   localparam logic [1:0] STB_LOW  = 2'b01;
   localparam logic [1:0] STB_HIGH = 2'b10;
   localparam logic [1:0] STB_ILL  = 2'b11;

   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_EARLY   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {IDLE, ARMED, PRE, DATA} state_t;

   state_t          state, state_nxt;
   logic            s_p, s_n;
   logic [DW-1:0]   s_dq;
   logic [1:0]      s_stb, prev_stb;
   logic [TW-1:0]   timer;
   logic [7:0]      beat_cnt;
   logic            timer_exp;
   logic            arm_ok;
   logic            strobe_changed;
   logic            last_idx;

   // Decoded control from the output logic
   logic            beat, beat_last, fail, tmr_clr, cnt_clr;
   logic [1:0]      fail_code;

   assign s_stb          = {s_p, s_n};
   assign timer_exp      = (timer >= TW'(TIMEOUT - 1));
   assign strobe_changed = (s_stb != prev_stb);
   assign last_idx       = (beat_cnt == 8'(BURST_LEN - 1));
   // busy covers the done/err cycle so it falls one cycle after the pulse
   assign busy           = (state != IDLE) | done | err;
   assign arm_ok         = arm & ~busy;

   // Input stage: one register per input plus the previous strobe level
   always_ff @(posedge clk) begin
      // NOTE: every register here and below is updated with <= so all of
      // them see the values from before the edge; = would chain them.
      if (rst) begin
         s_p      <= 1'b0;
         s_n      <= 1'b0;
         s_dq     <= '0;
         prev_stb <= STB_IDLE;
      end else begin
         s_p      <= dqs_p;
         s_n      <= dqs_n;
         s_dq     <= dq;
         prev_stb <= s_stb;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt
      // unassigned, which would infer a latch.
      state_nxt = state;
      case (state)
         IDLE:  if (arm_ok) state_nxt = ARMED;
         ARMED: begin
            case (s_stb)
               STB_LOW:  state_nxt = PRE;
               STB_HIGH: state_nxt = IDLE;
               STB_ILL:  state_nxt = IDLE;
               default:  if (timer_exp) state_nxt = IDLE;
            endcase
         end
         PRE: begin
            case (s_stb)
               STB_HIGH: state_nxt = DATA;
               STB_LOW:  if (timer_exp) state_nxt = IDLE;
               default:  state_nxt = IDLE;
            endcase
         end
         DATA: begin
            if (s_stb == STB_ILL || s_stb == STB_IDLE) state_nxt = IDLE;
            else if (strobe_changed) begin
               if (last_idx) state_nxt = IDLE;
            end else if (timer_exp) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: beat capture, errors and counter control
   always_comb begin
      beat      = 1'b0;
      beat_last = 1'b0;
      fail      = 1'b0;
      fail_code = 2'd0;
      tmr_clr   = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         IDLE: if (arm_ok) tmr_clr = 1'b1;
         ARMED: begin
            case (s_stb)
               STB_LOW: begin
                  tmr_clr = 1'b1;
                  cnt_clr = 1'b1;
               end
               STB_HIGH, STB_ILL: begin
                  fail      = 1'b1;
                  fail_code = ERR_ILLEGAL;
               end
               default: if (timer_exp) begin
                  fail      = 1'b1;
                  fail_code = ERR_TIMEOUT;
               end
            endcase
         end
         PRE: begin
            case (s_stb)
               STB_HIGH: begin
                  beat    = 1'b1;
                  tmr_clr = 1'b1;
               end
               STB_LOW: if (timer_exp) begin
                  fail      = 1'b1;
                  fail_code = ERR_TIMEOUT;
               end
               STB_IDLE: begin
                  fail      = 1'b1;
                  fail_code = ERR_EARLY;
               end
               default: begin
                  fail      = 1'b1;
                  fail_code = ERR_ILLEGAL;
               end
            endcase
         end
         DATA: begin
            // Errors are decoded ahead of the beat so they win over capture
            if (s_stb == STB_ILL) begin
               fail      = 1'b1;
               fail_code = ERR_ILLEGAL;
            end else if (s_stb == STB_IDLE) begin
               fail      = 1'b1;
               fail_code = ERR_EARLY;
            end else if (strobe_changed) begin
               beat      = 1'b1;
               beat_last = last_idx;
               tmr_clr   = 1'b1;
            end else if (timer_exp) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   // Event timer (saturating) and beat counter
   always_ff @(posedge clk) begin
      if (rst) begin
         timer    <= '0;
         beat_cnt <= '0;
      end else begin
         if (tmr_clr)                     timer <= '0;
         else if (timer != TW'(TIMEOUT))  timer <= timer + 1'b1;
         if (cnt_clr)   beat_cnt <= '0;
         else if (beat) beat_cnt <= beat_cnt + 8'd1;
      end
   end

   // Registered stream and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'd0;
      end else begin
         rd_valid <= beat;
         rd_last  <= beat_last;
         done     <= beat_last;
         err      <= fail;
         if (beat) rd_data  <= s_dq;
         if (fail) err_code <= fail_code;
      end
   end

endmodule

// File: tb/tb_mem_capture.sv
// Scoreboard bench for mem_capture: the driver pushes the expected stream
// events, and a monitor on the falling edge pops and compares them.
module tb_mem_capture;

   localparam int DW        = 8;
   localparam int BURST_LEN = 8;
   localparam int TIMEOUT   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          dqs_p, dqs_n;
   logic [DW-1:0] dq;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    err_code;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic       dn;
      logic       e;
      logic [1:0] c;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec  = 0;
   int  n_fail = 0;

   mem_capture #(.DW(DW), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .arm(arm), .dqs_p(dqs_p), .dqs_n(dqs_n), .dq(dq),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
      .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle with a stream or status pulse is one scoreboard event
   always @(negedge clk) begin
      ev_t obs;
      ev_t e;
      if (rd_valid || done || err) begin
         obs = '{v: rd_valid, d: (rd_valid ? rd_data : 8'h00), l: rd_last,
                 dn: done, e: err, c: (err ? err_code : 2'd0)};
         if (exp_q.size() == 0) check("unexpected_event", 32'(obs), 32'd0);
         else begin
            e = exp_q.pop_front();
            check("scoreboard_event", 32'(obs), 32'(e));
         end
      end
   end

   task automatic push_beat(input logic [7:0] d, input logic last);
      exp_q.push_back('{v: 1'b1, d: d, l: last, dn: last, e: 1'b0, c: 2'd0});
   endtask

   task automatic push_err(input logic [1:0] code);
      exp_q.push_back('{v: 1'b0, d: 8'h00, l: 1'b0, dn: 1'b0, e: 1'b1, c: code});
   endtask

   // One clock of stimulus: values are sampled on the next rising edge
   task automatic cyc(input logic [1:0] stb, input logic [7:0] d, input logic a);
      {dqs_p, dqs_n} = stb;
      dq  = d;
      arm = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(2'b00, 8'h00, 1'b0);
   endtask

   task automatic arm_pre(input int hold);
      cyc(2'b00, 8'h00, 1'b1);
      for (int i = 0; i < hold; i++) cyc(2'b01, 8'h00, 1'b0);
   endtask

   // nb beats starting with high, data = base*(k+1), each level held 'hold'
   task automatic run_burst(input int hold, input int nb, input logic [7:0] base);
      for (int k = 0; k < nb; k++) begin
         logic [1:0] stb;
         logic [7:0] d;
         stb = (k % 2 == 0) ? 2'b10 : 2'b01;
         d   = 8'(base * (k + 1));
         push_beat(d, k == BURST_LEN - 1);
         for (int h = 0; h < hold; h++) cyc(stb, d, 1'b0);
      end
   endtask

   task automatic drain(input string name);
      idle(4);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_rd_data"},  32'(rd_data),  32'd0);
      check({tag, "_rd_last"},  32'(rd_last),  32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_err"},      32'(err),      32'd0);
      check({tag, "_err_code"}, 32'(err_code), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      arm = 1'b0;
      {dqs_p, dqs_n} = 2'b00;
      dq  = '0;
      @(posedge clk);
      #1;
      idle(2);
      check_reset_outputs("reset");
      rst = 1'b0;
      idle(2);

      // Normal burst: one preamble cycle, 8 beats 0x11..0x88
      arm_pre(1);
      check("normal_busy_rise", 32'(busy), 32'd1);
      run_burst(1, 8, 8'h11);
      cyc(2'b00, 8'h00, 1'b0);
      check("normal_done", 32'(done), 32'd1);
      check("normal_busy_in_done", 32'(busy), 32'd1);
      // arm during the done cycle is ignored because busy is still high
      cyc(2'b00, 8'h00, 1'b1);
      check("normal_busy_fall", 32'(busy), 32'd0);
      drain("normal_drain");

      // Slow strobe: every level held 3 cycles
      arm_pre(3);
      run_burst(3, 8, 8'h13);
      drain("slow_drain");

      // Early postamble after 3 beats
      arm_pre(1);
      run_burst(1, 3, 8'h21);
      push_err(2'd2);
      idle(1);
      drain("early_drain");
      check("early_err_code_hold", 32'(err_code), 32'd2);

      // Illegal strobe in the middle of DATA
      arm_pre(1);
      run_burst(1, 3, 8'h31);
      push_err(2'd1);
      cyc(2'b11, 8'hEE, 1'b0);
      drain("illegal_mid_drain");

      // Illegal strobe on the last-beat cycle: err, no rd_valid
      arm_pre(1);
      run_burst(1, 7, 8'h05);
      push_err(2'd1);
      cyc(2'b11, 8'hFF, 1'b0);
      drain("illegal_last_drain");

      // Timeout with the strobe held idle; extra arm while busy is ignored
      push_err(2'd3);
      cyc(2'b00, 8'h00, 1'b1);
      check("timeout_busy", 32'(busy), 32'd1);
      for (int i = 1; i < TIMEOUT; i++) cyc(2'b00, 8'h00, i == 5);
      check("timeout_not_yet", 32'(err), 32'd0);
      cyc(2'b00, 8'h00, 1'b0);
      check("timeout_err", 32'(err), 32'd1);
      check("timeout_code", 32'(err_code), 32'd3);
      drain("timeout_drain");
      check("timeout_idle", 32'(busy), 32'd0);

      // Reset mid-burst after 4 beats have been reported
      arm_pre(1);
      for (int k = 0; k < 5; k++) begin
         logic [7:0] d;
         d = 8'(8'h50 + k);
         if (k < 4) push_beat(d, 1'b0);
         cyc((k % 2 == 0) ? 2'b10 : 2'b01, d, 1'b0);
      end
      rst = 1'b1;
      cyc(2'b01, 8'h55, 1'b0);
      rst = 1'b0;
      check_reset_outputs("midrst");
      cyc(2'b10, 8'h56, 1'b0);
      cyc(2'b01, 8'h57, 1'b0);
      drain("midrst_drain");

      // A fresh burst after the reset still completes with done
      arm_pre(1);
      run_burst(1, 8, 8'h09);
      cyc(2'b00, 8'h00, 1'b0);
      check("recover_done", 32'(done), 32'd1);
      drain("recover_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_capture.md
# mem_capture

Receive-side counterpart of the rank strobe/data driver. It watches the differential strobe (`dqs_p`/`dqs_n`) and the `dq` bus in the system clock domain and detects the preamble. It captures one `dq` byte on every strobe level change (both edges, DDR style) and presents the bytes as a valid-qualified stream with burst-complete and error flags. It sits on the controller side of `IfMEM`, opposite the rank, and returns read bursts to the memory test logic.

## Interface
- `DW`, 8, width of `dq` and `rd_data`
- `BURST_LEN`, 8, beats per burst (≥2, ≤255)
- `TIMEOUT`, 16, max clk cycles allowed between consecutive strobe events once armed (≥2)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  one-cycle pulse: accept the next burst
- `dqs_p`  in  1  strobe, true leg
- `dqs_n`  in  1  strobe, complement leg
- `dq`  in  DW  data bus
- `rd_valid`  out  1  one-cycle pulse per captured beat
- `rd_data`  out  DW  captured byte, valid with `rd_valid`
- `rd_last`  out  1  high with the final beat's `rd_valid`
- `busy`  out  1  high from accepted `arm` until return to IDLE
- `done`  out  1  one-cycle pulse: burst completed cleanly
- `err`  out  1  one-cycle pulse: burst aborted
- `err_code`  out  2  valid with `err`: 1=illegal strobe, 2=early postamble, 3=timeout

## Operation
- Strobe decode on the registered sample `{p,n}`: `00`=idle, `01`=low, `10`=high, `11`=illegal.
- Input stage: `dqs_p`, `dqs_n`, `dq` registered once each cycle into `s_*`. A second register holds the previous strobe level for edge detection. No input synchronizers are needed because the strobe is generated from `clk`.
- FSM states: IDLE, ARMED, PRE, DATA.
- IDLE: `arm`=1 → ARMED. A strobe on the bus while in IDLE is ignored.
- ARMED: `s` = low → PRE. `s` = high or illegal → `err`, code 1, → IDLE. Timer expiry → `err`, code 3, → IDLE.
- PRE: stays while `s` = low. `s` = high counts as beat 0 → DATA. `s` = idle → code 2. `s` = illegal → code 1.
- DATA: each change between low and high is one beat. `rd_data` ← `s_dq` from the same sample, `rd_valid`=1, and the beat counter increments.
  - Beat index `BURST_LEN-1` asserts `rd_last`, then the FSM goes to IDLE with `done`=1 in the same cycle.
  - `s` = idle before the last beat → code 2.
  - `s` = illegal → code 1.
  - Level unchanged → no beat; the timer runs.
- Timer: counts cycles since the last strobe event (entry to ARMED counts as an event). It reaches `TIMEOUT` → code 3. The counter is wide enough for `TIMEOUT`, and it saturates rather than wrapping.
- Beat counter: 8 bits, cleared on entry to PRE.
- `arm` while `busy` is ignored. It is not queued.
- After `done` or `err`, the FSM returns to IDLE. The rank's postamble (strobe back to idle) that follows is ignored because the FSM is in IDLE.
- Simultaneous events: `err` has priority over beat capture. An illegal strobe in the cycle that would have been the last beat gives `err` and no `rd_valid`.

## Timing
- Reset: FSM=IDLE, counters=0, `s_*`=0.
  - Outputs after reset: `rd_valid`=0, `rd_data`=0, `rd_last`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0.
- `rd_data` holds its value between beats. `err_code` holds until the next `err`.
- Latency: a strobe level change and its `dq` presented before edge N are reported as `rd_valid` with that data during the cycle after edge N+1. That is a fixed 2-cycle latency.
- `busy` rises the cycle after `arm` and falls in the cycle after `done`/`err`.
- Maximum beat rate is 1 per clk, so the strobe may toggle every cycle.
- `rst` mid-burst: the burst is abandoned in the next cycle. No `done`/`err` is issued, all outputs take their reset values, and strobe activity continues to be ignored until a new `arm`.

## Test plan
- Normal burst: BURST_LEN=8, `arm`, then 1 preamble cycle, then 8 alternating strobe cycles with dq=0x11..0x88 → 8 `rd_valid` carrying 0x11..0x88 in order, `rd_last` on 0x88, `done` in the same cycle, `busy` drops next cycle.
- Slow strobe: each strobe level held 3 cycles, TIMEOUT=16 → still exactly 8 beats and no duplicate captures.
- Early postamble: strobe returns to `00` after 3 beats → 3 `rd_valid`, `err`=1 with `err_code`=2, no `done`.
- Illegal strobe: `dqs_p`=`dqs_n`=1 during DATA → `err`, code 1, and no `rd_valid` in that cycle. Repeat with the illegal value on the last-beat cycle → same result.
- Timeout: `arm` with the strobe held idle → `err` with code 3 exactly TIMEOUT cycles after ARMED entry. A second `arm` pulse while busy has no effect.
- Reset mid-burst: `rst` after beat 4 → all outputs 0 next cycle, and the remaining strobes produce nothing. A new `arm` plus a full burst then completes with `done`.
